// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared answer-game constants and sequencer state encoding
package game_pkg;

  localparam int DIGIT_W   = 4;
  localparam int DIGITS    = 8;
  localparam int MAX_DIGIT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_CHECK,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/digit_range_check.sv
// rtl/digit_range_check.sv - flags a packed word whose every digit lies in 1..MAX_DIGIT
module digit_range_check #(
  parameter int DIGITS    = game_pkg::DIGITS,
  parameter int MAX_DIGIT = game_pkg::MAX_DIGIT
) (
  input  logic [DIGITS*game_pkg::DIGIT_W-1:0] word,
  output logic                                all_valid
);
  import game_pkg::*;

  localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MAX_DIGIT);

  always_comb begin
    all_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if ((word[i*DIGIT_W +: DIGIT_W] == '0) || (word[i*DIGIT_W +: DIGIT_W] > MAX_D))
        all_valid = 1'b0;
    end
  end

endmodule

// File: rtl/answer_sequencer.sv
// rtl/answer_sequencer.sv - fetches a random word, validates it and writes it digit by digit
module answer_sequencer #(
  parameter int DIGITS    = game_pkg::DIGITS,
  parameter int MAX_DIGIT = game_pkg::MAX_DIGIT,
  parameter int TIMEOUT   = 15,
  parameter int MAX_RETRY = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                new_game,
  output logic                                gen_req,
  input  logic                                gen_valid,
  input  logic [DIGITS*game_pkg::DIGIT_W-1:0] gen_data,
  output logic                                ans_we,
  output logic [2:0]                          ans_addr,
  output logic [game_pkg::DIGIT_W-1:0]        ans_wdata,
  output logic                                busy,
  output logic                                answer_ready,
  output logic                                error
);
  import game_pkg::*;

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRY);
  localparam logic [2:0]       IDX_LAST  = 3'(DIGITS - 1);

  state_t                     state;
  logic [TMO_W-1:0]           tmo_cnt;
  logic [RTY_W-1:0]           retry_cnt;
  logic [RTY_W-1:0]           retry_inc;
  logic [2:0]                 idx;
  logic [2:0]                 idx_inc;
  logic [DIGITS*DIGIT_W-1:0]  word_q;
  logic [DIGIT_W-1:0]         next_digit;
  logic                       all_valid;
  logic                       attempt_failed;

  digit_range_check #(
    .DIGITS    (DIGITS),
    .MAX_DIGIT (MAX_DIGIT)
  ) u_range_check (
    .word      (word_q),
    .all_valid (all_valid)
  );

  // A timeout and a rejected word are the same kind of failed attempt.
  always_comb begin
    retry_inc      = retry_cnt + 1'b1;
    idx_inc        = idx + 3'd1;
    next_digit     = word_q[idx_inc*DIGIT_W +: DIGIT_W];
    attempt_failed = ((state == ST_WAIT) && !gen_valid && (tmo_cnt == TMO_LAST)) ||
                     ((state == ST_CHECK) && !all_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      gen_req      <= 1'b0;
      ans_we       <= 1'b0;
      ans_addr     <= '0;
      ans_wdata    <= '0;
      busy         <= 1'b0;
      answer_ready <= 1'b0;
      error        <= 1'b0;
      tmo_cnt      <= '0;
      retry_cnt    <= '0;
      idx          <= '0;
      word_q       <= '0;
    end else begin
      gen_req   <= 1'b0;
      ans_we    <= 1'b0;
      ans_addr  <= '0;
      ans_wdata <= '0;
      if (attempt_failed) begin
        retry_cnt <= retry_inc;
        if (retry_inc == RTY_LIMIT) begin
          state <= ST_ERROR;
          busy  <= 1'b0;
          error <= 1'b1;
        end else begin
          state   <= ST_REQ;
          gen_req <= 1'b1;
        end
      end else begin
        case (state)
          ST_IDLE, ST_DONE, ST_ERROR: begin
            if (new_game) begin
              state        <= ST_REQ;
              gen_req      <= 1'b1;
              busy         <= 1'b1;
              answer_ready <= 1'b0;
              error        <= 1'b0;
              retry_cnt    <= '0;
            end
          end
          ST_REQ: begin
            tmo_cnt <= '0;
            state   <= ST_WAIT;
          end
          ST_WAIT: begin
            if (gen_valid) begin
              word_q <= gen_data;
              state  <= ST_CHECK;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          ST_CHECK: begin
            state     <= ST_WRITE;
            idx       <= '0;
            ans_we    <= 1'b1;
            ans_addr  <= '0;
            ans_wdata <= word_q[DIGIT_W-1:0];
          end
          ST_WRITE: begin
            if (idx == IDX_LAST) begin
              state        <= ST_DONE;
              busy         <= 1'b0;
              answer_ready <= 1'b1;
              retry_cnt    <= '0;
            end else begin
              idx       <= idx_inc;
              ans_we    <= 1'b1;
              ans_addr  <= idx_inc;
              ans_wdata <= next_digit;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_answer_sequencer.sv
// tb/tb_answer_sequencer.sv - randomized bench against a per-game event-timeline model
module tb_answer_sequencer;

  localparam int TIMEOUT = 15;
  localparam int N       = 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        new_game = 1'b0;
  logic        gen_valid = 1'b0;
  logic [31:0] gen_data = '0;
  logic        gen_req;
  logic        ans_we;
  logic [2:0]  ans_addr;
  logic [3:0]  ans_wdata;
  logic        busy;
  logic        answer_ready;
  logic        error;

  answer_sequencer #(
    .DIGITS(8), .MAX_DIGIT(8), .TIMEOUT(TIMEOUT), .MAX_RETRY(3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .new_game     (new_game),
    .gen_req      (gen_req),
    .gen_valid    (gen_valid),
    .gen_data     (gen_data),
    .ans_we       (ans_we),
    .ans_addr     (ans_addr),
    .ans_wdata    (ans_wdata),
    .busy         (busy),
    .answer_ready (answer_ready),
    .error        (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Attempt plan for one game: timeout, or word delivered k cycles after gen_req.
  int          n_att;
  bit          p_to[3];
  int          p_k[3];
  logic [31:0] p_w[3];

  // Expected outputs per sample step s (step 0 = cycle new_game is driven).
  bit          e_req[N], e_we[N], e_busy[N], e_rdy[N], e_err[N];
  logic [2:0]  e_addr[N];
  logic [3:0]  e_data[N];
  bit          in_wait[N], gv_at[N];
  logic [31:0] gd_at[N];
  int          end_s;

  function automatic bit word_ok(input logic [31:0] w);
    for (int i = 0; i < 8; i++) begin
      int d;
      d = int'((w >> (4*i)) & 32'hF);
      if (d < 1 || d > 8) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] rand_good();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w = w | (32'($urandom_range(1, 8)) << (4*i));
    return w;
  endfunction

  task automatic build_timeline();
    int g, fails, nxt, k;
    bit fin, failed, ok_end;
    for (int s = 0; s < N; s++) begin
      e_req[s] = 0; e_we[s] = 0; e_busy[s] = 0; e_rdy[s] = 0; e_err[s] = 0;
      e_addr[s] = '0; e_data[s] = '0; in_wait[s] = 0; gv_at[s] = 0; gd_at[s] = '0;
    end
    g = 1; fails = 0; fin = 0; end_s = 0; ok_end = 0; nxt = 0;
    for (int a = 0; a < n_att && !fin; a++) begin
      failed = 0;
      k = p_k[a];
      e_req[g] = 1;
      if (p_to[a]) begin
        for (int j = 1; j <= TIMEOUT; j++) in_wait[g+j] = 1;
        nxt = g + TIMEOUT + 1;
        failed = 1;
      end else begin
        for (int j = 1; j <= k; j++) in_wait[g+j] = 1;
        gv_at[g+k] = 1;
        gd_at[g+k] = p_w[a];
        if (word_ok(p_w[a])) begin
          for (int i = 0; i < 8; i++) begin
            e_we[g+k+2+i]   = 1;
            e_addr[g+k+2+i] = 3'(i);
            e_data[g+k+2+i] = 4'((p_w[a] >> (4*i)) & 32'hF);
          end
          end_s = g + k + 10;
          ok_end = 1;
          fin = 1;
        end else begin
          nxt = g + k + 2;
          failed = 1;
        end
      end
      if (failed) begin
        fails++;
        if (fails == 3) begin
          end_s = nxt;
          fin = 1;
        end else begin
          g = nxt;
        end
      end
    end
    for (int s = 1; s < end_s; s++) e_busy[s] = 1;
    for (int s = end_s; s < N; s++) begin
      e_rdy[s] = ok_end;
      e_err[s] = !ok_end;
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({gen_req, ans_we, ans_addr, ans_wdata, busy, answer_ready, error});
  endfunction

  task automatic run_game(input string name, input int abort_at);
    logic [31:0] obs, expv;
    build_timeline();
    for (int s = 0; s <= end_s + 2; s++) begin
      if (s > 0) begin
        obs  = 32'({gen_req, ans_we, e_we[s] ? ans_addr : 3'b0, e_we[s] ? ans_wdata : 4'b0,
                    busy, answer_ready, error});
        expv = 32'({e_req[s], e_we[s], e_addr[s], e_data[s], e_busy[s], e_rdy[s], e_err[s]});
        check_val($sformatf("%s@%0d", name, s), obs, expv);
      end
      if (s == abort_at) begin
        new_game  = 1'b0;
        gen_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_val($sformatf("%s_rst_async", name), all_outs(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
          @(posedge clk); @(negedge clk);
          check_val($sformatf("%s_idle_after_rst%0d", name, c), all_outs(), 32'h0);
        end
        return;
      end
      new_game  = (s == 0) || (s < end_s && $urandom_range(0, 3) == 0);
      gen_valid = gv_at[s] || (!in_wait[s] && $urandom_range(0, 3) == 0);
      gen_data  = gv_at[s] ? gd_at[s] : $urandom;
      @(posedge clk); @(negedge clk);
    end
    new_game  = 1'b0;
    gen_valid = 1'b0;
  endtask

  task automatic random_plan();
    int r, pos;
    n_att = 0;
    for (int a = 0; a < 3; a++) begin
      r = $urandom_range(0, 3);
      p_to[a] = (r == 0);
      p_k[a]  = $urandom_range(1, TIMEOUT);
      p_w[a]  = rand_good();
      if (r == 1) begin
        pos = $urandom_range(0, 7);
        p_w[a] = (p_w[a] & ~(32'hF << (4*pos))) |
                 (32'(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 15)) << (4*pos));
      end
      n_att++;
      if (r >= 2) break;
    end
  endtask

  initial begin
    @(negedge clk); @(negedge clk);
    check_val("reset_outs", all_outs(), 32'h0);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); @(negedge clk);
      check_val($sformatf("idle%0d", c), all_outs(), 32'h0);
    end

    n_att = 1; p_to[0] = 0; p_k[0] = 2; p_w[0] = 32'h8765_4321;
    run_game("t1_basic", -1);

    n_att = 2; p_to[0] = 0; p_k[0] = 3; p_w[0] = 32'h1234_5670;
    p_to[1] = 0; p_k[1] = 1; p_w[1] = 32'h1111_1111;
    run_game("t2_retry", -1);

    n_att = 3; p_to[0] = 1; p_to[1] = 1; p_to[2] = 1;
    p_k[0] = 1; p_k[1] = 1; p_k[2] = 1;
    run_game("t3_timeout", -1);

    n_att = 1; p_to[0] = 0; p_k[0] = TIMEOUT; p_w[0] = 32'h8888_8888;
    run_game("t4_from_err", -1);

    n_att = 1; p_to[0] = 0; p_k[0] = 2; p_w[0] = 32'h2468_1357;
    run_game("t5_reset", 8);

    n_att = 3; p_to[0] = 0; p_k[0] = 4; p_w[0] = 32'h9111_1111;
    p_to[1] = 0; p_k[1] = 1; p_w[1] = 32'h111F_1111;
    p_to[2] = 0; p_k[2] = 2; p_w[2] = 32'h1818_1818;
    run_game("t6_range", -1);

    for (int n = 0; n < 25; n++) begin
      random_plan();
      run_game($sformatf("rnd%0d", n), -1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
